// File: rtl/matrix_pkg.sv
// Shared constants for the 5x5 matrix datapath (multiply unit and result
// streamer): matrix geometry, the packed-bus element offset helper and the
// streamer state encoding.
package matrix_pkg;

  localparam int unsigned MAX_DIM    = 5;
  localparam int unsigned ELEM_WIDTH = 8;
  localparam int unsigned MAX_ELEM   = MAX_DIM * MAX_DIM;

  // Streamer state encoding
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_HDR_M = 3'd1;
  localparam logic [2:0] ST_HDR_N = 3'd2;
  localparam logic [2:0] ST_DATA  = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  // Bit offset of element (i,j) in the row-major packed matrix bus
  function automatic int unsigned elem_offset(input int unsigned i, input int unsigned j);
    return (i * MAX_DIM + j) * ELEM_WIDTH;
  endfunction

endpackage

// File: rtl/matrix_index_counter.sv
// Row/column walker over an m x n matrix.
// Ports:
//   clk_i, rst_ni        clock, asynchronous active-low reset
//   clear_i              return to (0,0) (has priority over advance_i)
//   advance_i            step to the next element in row-major order
//   m_i, n_i             row / column bounds (1..5)
//   row_o, col_o         current indices (registered)
//   eol_o, last_o        current index is last column / last element
//   row_nxt_o, col_nxt_o indices after this cycle's clear/advance
//   eol_nxt_o, last_nxt_o eol/last evaluated on the next indices
module matrix_index_counter (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       clear_i,
  input  logic       advance_i,
  input  logic [2:0] m_i,
  input  logic [2:0] n_i,
  output logic [2:0] row_o,
  output logic [2:0] col_o,
  output logic       eol_o,
  output logic       last_o,
  output logic [2:0] row_nxt_o,
  output logic [2:0] col_nxt_o,
  output logic       eol_nxt_o,
  output logic       last_nxt_o
);

  logic [2:0] row_q, row_d;
  logic [2:0] col_q, col_d;

  assign eol_o  = (col_q == n_i - 3'd1);
  assign last_o = eol_o && (row_q == m_i - 3'd1);

  // Wrapping to (0,0) after the final element keeps indices within 0..4.
  always_comb begin
    row_d = row_q;
    col_d = col_q;
    if (clear_i) begin
      row_d = '0;
      col_d = '0;
    end else if (advance_i) begin
      if (last_o) begin
        row_d = '0;
        col_d = '0;
      end else if (eol_o) begin
        row_d = row_q + 3'd1;
        col_d = '0;
      end else begin
        col_d = col_q + 3'd1;
      end
    end
  end

  assign eol_nxt_o  = (col_d == n_i - 3'd1);
  assign last_nxt_o = eol_nxt_o && (row_d == m_i - 3'd1);
  assign row_nxt_o  = row_d;
  assign col_nxt_o  = col_d;
  assign row_o      = row_q;
  assign col_o      = col_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      row_q <= '0;
      col_q <= '0;
    end else begin
      row_q <= row_d;
      col_q <= col_d;
    end
  end

endmodule

// File: rtl/matrix_result_streamer.sv
// Captures a packed row-major matrix on start and streams it as two header
// beats (rows, cols) followed by one element per beat over valid/ready.
// Ports:
//   clk, reset (async active-low)
//   start, m_in, n_in, matrix_in     capture request, dimensions, packed matrix
//   elem_valid/elem_ready            beat handshake
//   elem_data, elem_hdr              beat payload, header flag
//   elem_row, elem_col               element indices (0 on header beats)
//   elem_eol, elem_last              end of row / end of matrix qualifiers
//   busy, done, err                  status; done/err are one-cycle pulses
module matrix_result_streamer #(
  parameter int unsigned MAX_DIM    = matrix_pkg::MAX_DIM,
  parameter int unsigned ELEM_WIDTH = matrix_pkg::ELEM_WIDTH,
  parameter int unsigned MAX_ELEM   = matrix_pkg::MAX_ELEM
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           start,
  input  logic [2:0]                     m_in,
  input  logic [2:0]                     n_in,
  input  logic [MAX_ELEM*ELEM_WIDTH-1:0] matrix_in,
  output logic                           elem_valid,
  input  logic                           elem_ready,
  output logic [ELEM_WIDTH-1:0]          elem_data,
  output logic                           elem_hdr,
  output logic [2:0]                     elem_row,
  output logic [2:0]                     elem_col,
  output logic                           elem_eol,
  output logic                           elem_last,
  output logic                           busy,
  output logic                           done,
  output logic                           err
);

  logic [2:0]                     state_q, state_d;
  logic [MAX_ELEM*ELEM_WIDTH-1:0] mat_q, mat_d;
  logic [2:0]                     m_q, m_d, n_q, n_d;
  logic                           valid_q, valid_d;
  logic [ELEM_WIDTH-1:0]          data_q, data_d;
  logic                           hdr_q, hdr_d;
  logic                           eol_q, eol_d;
  logic                           last_q, last_d;
  logic                           busy_q, busy_d;
  logic                           done_q, done_d;
  logic                           err_q, err_d;

  logic       xfer, dims_ok;
  logic       cnt_clear, cnt_adv;
  logic [2:0] cnt_row, cnt_col, cnt_row_nxt, cnt_col_nxt;
  logic       cnt_eol, cnt_last, cnt_eol_nxt, cnt_last_nxt;
  int unsigned off_nxt;

  assign xfer    = valid_q && elem_ready;
  assign dims_ok = (m_in != 3'd0) && (m_in <= 3'(MAX_DIM)) &&
                   (n_in != 3'd0) && (n_in <= 3'(MAX_DIM));

  assign cnt_clear = (state_q == matrix_pkg::ST_IDLE) && start && dims_ok;
  assign cnt_adv   = (state_q == matrix_pkg::ST_DATA) && xfer;

  matrix_index_counter u_idx (
    .clk_i      (clk),
    .rst_ni     (reset),
    .clear_i    (cnt_clear),
    .advance_i  (cnt_adv),
    .m_i        (m_q),
    .n_i        (n_q),
    .row_o      (cnt_row),
    .col_o      (cnt_col),
    .eol_o      (cnt_eol),
    .last_o     (cnt_last),
    .row_nxt_o  (cnt_row_nxt),
    .col_nxt_o  (cnt_col_nxt),
    .eol_nxt_o  (cnt_eol_nxt),
    .last_nxt_o (cnt_last_nxt)
  );

  // Outputs are registered, so each beat's payload is prepared from the
  // counter's next indices in the cycle the previous beat transfers.
  always_comb begin
    off_nxt = matrix_pkg::elem_offset(32'(cnt_row_nxt), 32'(cnt_col_nxt));
  end

  always_comb begin
    state_d = state_q;
    mat_d   = mat_q;
    m_d     = m_q;
    n_d     = n_q;
    valid_d = valid_q;
    data_d  = data_q;
    hdr_d   = hdr_q;
    eol_d   = eol_q;
    last_d  = last_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      matrix_pkg::ST_IDLE: begin
        if (start) begin
          if (dims_ok) begin
            mat_d   = matrix_in;
            m_d     = m_in;
            n_d     = n_in;
            state_d = matrix_pkg::ST_HDR_M;
            valid_d = 1'b1;
            hdr_d   = 1'b1;
            data_d  = ELEM_WIDTH'(m_in);
            eol_d   = 1'b0;
            last_d  = 1'b0;
            busy_d  = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      matrix_pkg::ST_HDR_M: begin
        if (xfer) begin
          state_d = matrix_pkg::ST_HDR_N;
          data_d  = ELEM_WIDTH'(n_q);
        end
      end
      matrix_pkg::ST_HDR_N: begin
        if (xfer) begin
          // Counter sits at (0,0) since capture.
          state_d = matrix_pkg::ST_DATA;
          hdr_d   = 1'b0;
          data_d  = mat_q[ELEM_WIDTH-1:0];
          eol_d   = cnt_eol;
          last_d  = cnt_last;
        end
      end
      matrix_pkg::ST_DATA: begin
        if (xfer) begin
          if (cnt_last) begin
            state_d = matrix_pkg::ST_DONE;
            valid_d = 1'b0;
            data_d  = '0;
            eol_d   = 1'b0;
            last_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            data_d = mat_q[off_nxt +: ELEM_WIDTH];
            eol_d  = cnt_eol_nxt;
            last_d = cnt_last_nxt;
          end
        end
      end
      matrix_pkg::ST_DONE: begin
        state_d = matrix_pkg::ST_IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = matrix_pkg::ST_IDLE;
        valid_d = 1'b0;
        hdr_d   = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= matrix_pkg::ST_IDLE;
      mat_q   <= '0;
      m_q     <= '0;
      n_q     <= '0;
      valid_q <= 1'b0;
      data_q  <= '0;
      hdr_q   <= 1'b0;
      eol_q   <= 1'b0;
      last_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      mat_q   <= mat_d;
      m_q     <= m_d;
      n_q     <= n_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      hdr_q   <= hdr_d;
      eol_q   <= eol_d;
      last_q  <= last_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign elem_valid = valid_q;
  assign elem_data  = data_q;
  assign elem_hdr   = hdr_q;
  assign elem_row   = cnt_row;
  assign elem_col   = cnt_col;
  assign elem_eol   = eol_q;
  assign elem_last  = last_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign err        = err_q;

endmodule
